// File: rtl/cla_seq_adder_ctrl.sv
// cla_seq_adder_ctrl: WIDTH-bit adder sequenced nibble-by-nibble (LSB first) through one external 4-bit CLA.
// Ports: clk/rst_n (async active-low reset); in_valid/in_ready + a, b, c_in (operand side);
// out_valid/out_ready + sum, c_out, ovf (registered result side); busy (RUN or DONE);
// cla_a/cla_b/cla_cin drive the external CLA, cla_sum/cla_cout return its combinational result.
module cla_seq_adder_ctrl #(
  parameter int WIDTH = 16,
  parameter int NW = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             busy,
  output logic [3:0]       cla_a,
  output logic [3:0]       cla_b,
  output logic             cla_cin,
  input  logic [3:0]       cla_sum,
  input  logic             cla_cout
);
  localparam int IW = NW > 1 ? $clog2(NW) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic carry, last, accept;
  assign last = idx == IW'(NW - 1);
  assign accept = in_valid && in_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    in_ready = rst_n && state == IDLE;
    out_valid = state == DONE;
    busy = state != IDLE;
    cla_a = state == RUN ? a_reg[{idx, 2'b00} +: 4] : 4'h0;
    cla_b = state == RUN ? b_reg[{idx, 2'b00} +: 4] : 4'h0;
    cla_cin = state == RUN ? carry : 1'b0;
    state_nx = state;
    if (state == IDLE && accept) state_nx = RUN;
    if (state == RUN && last) state_nx = DONE;
    if (state == DONE && out_ready) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      carry <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      sum <= '0;
      c_out <= 1'b0;
      ovf <= 1'b0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= b;
      carry <= c_in;
      idx <= '0;
    end else if (state == RUN) begin
      sum[{idx, 2'b00} +: 4] <= cla_sum;
      carry <= cla_cout;
      idx <= idx + IW'(1);
      if (last) begin
        c_out <= cla_cout;
        // operands agree in sign but the top result bit disagrees
        ovf <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (cla_sum[3] != a_reg[WIDTH-1]);
      end
    end
endmodule
